uart_cmd_wrapper: RTL and testbench



---
 rtl/uart_cmd_wrapper.sv | 169 ++++++++++++++++
 tb/tb_uart_cmd_wrapper.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_wrapper.sv
// UART command wrapper: packs two received bytes into a 16-bit command and
// forwards one response byte to the UART transmitter. Optional inter-byte timeout: UCW_TIMEOUT_EN.
module uart_cmd_wrapper #(
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int TO_W           = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_rdy,
    output logic        clr_rx_rdy,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    output logic        cmd_ovr,
    output logic        frame_err,
    input  logic [7:0]  resp,
    input  logic        send_resp,
    output logic        resp_sent,
    output logic [7:0]  tx_data,
    output logic        trmt,
    input  logic        tx_done
);

    typedef enum logic { RX_HI = 1'b0, RX_LO = 1'b1 } rx_state_t;
    typedef enum logic { TX_IDLE = 1'b0, TX_BUSY = 1'b1 } tx_state_t;

    // The timeout counter must be able to reach TIMEOUT_CYCLES-1.
    if (TO_W < 1 || TIMEOUT_CYCLES < 1 || (TO_W < 31 && (1 << TO_W) <= TIMEOUT_CYCLES)) begin : g_bad_to_w
        $error("uart_cmd_wrapper: TO_W too narrow for TIMEOUT_CYCLES");
    end

    rx_state_t   rx_state_q, rx_state_d;
    logic [7:0]  cmd_hi_q, cmd_hi_d;
    logic [15:0] cmd_q, cmd_d;
    logic        cmd_rdy_q, cmd_rdy_d;
    logic        cmd_ovr_q, cmd_ovr_d;
    logic        frame_err_q, frame_err_d;
    logic        rx_done;
    logic        rx_timeout;
    logic        to_hit;

    tx_state_t   tx_state_q, tx_state_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        trmt_q, trmt_d;
    logic        resp_sent_q, resp_sent_d;
    logic        tx_accept;

`ifdef UCW_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    assign to_hit = (rx_state_q == RX_LO) && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        to_cnt_d = '0;
        if (rx_state_q == RX_LO && rx_state_d == RX_LO)
            to_cnt_d = to_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) to_cnt_q <= '0;
        else     to_cnt_q <= to_cnt_d;
    end
`else
    assign to_hit = 1'b0;
`endif

    // State and data registers for both paths.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state_q  <= RX_HI;
            cmd_hi_q    <= '0;
            cmd_q       <= '0;
            cmd_rdy_q   <= 1'b0;
            cmd_ovr_q   <= 1'b0;
            frame_err_q <= 1'b0;
            tx_state_q  <= TX_IDLE;
            tx_data_q   <= '0;
            trmt_q      <= 1'b0;
            resp_sent_q <= 1'b0;
        end else begin
            rx_state_q  <= rx_state_d;
            cmd_hi_q    <= cmd_hi_d;
            cmd_q       <= cmd_d;
            cmd_rdy_q   <= cmd_rdy_d;
            cmd_ovr_q   <= cmd_ovr_d;
            frame_err_q <= frame_err_d;
            tx_state_q  <= tx_state_d;
            tx_data_q   <= tx_data_d;
            trmt_q      <= trmt_d;
            resp_sent_q <= resp_sent_d;
        end
    end

    // Receive next-state; a byte arriving on the timeout cycle still completes the command.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_done    = 1'b0;
        rx_timeout = 1'b0;
        case (rx_state_q)
            RX_HI: begin
                if (rx_rdy) rx_state_d = RX_LO;
            end
            RX_LO: begin
                if (rx_rdy) begin
                    rx_state_d = RX_HI;
                    rx_done    = 1'b1;
                end else if (to_hit) begin
                    rx_state_d = RX_HI;
                    rx_timeout = 1'b1;
                end
            end
            default: rx_state_d = RX_HI;
        endcase
    end

    always_comb begin
        cmd_hi_d    = cmd_hi_q;
        cmd_d       = cmd_q;
        cmd_ovr_d   = 1'b0;
        frame_err_d = rx_timeout;
        if (rx_state_q == RX_HI && rx_rdy) cmd_hi_d = rx_data;
        if (rx_timeout)                    cmd_hi_d = '0;
        if (rx_done) begin
            cmd_d     = {cmd_hi_q, rx_data};
            cmd_ovr_d = cmd_rdy_q & ~clr_cmd_rdy;
        end
        cmd_rdy_d = rx_done | (cmd_rdy_q & ~clr_cmd_rdy);
    end

    // Transmit next-state; requests while busy are dropped.
    always_comb begin
        tx_state_d  = tx_state_q;
        tx_accept   = 1'b0;
        tx_data_d   = tx_data_q;
        resp_sent_d = resp_sent_q;
        case (tx_state_q)
            TX_IDLE: begin
                if (send_resp) begin
                    tx_accept   = 1'b1;
                    tx_data_d   = resp;
                    resp_sent_d = 1'b0;
                    tx_state_d  = TX_BUSY;
                end
            end
            TX_BUSY: begin
                if (tx_done) begin
                    resp_sent_d = 1'b1;
                    tx_state_d  = TX_IDLE;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
        trmt_d = tx_accept;
    end

    // Outputs; every received byte is consumed in whichever state it arrives.
    always_comb begin
        clr_rx_rdy = rx_rdy & ~rst;
        cmd        = cmd_q;
        cmd_rdy    = cmd_rdy_q;
        cmd_ovr    = cmd_ovr_q;
        frame_err  = frame_err_q;
        tx_data    = tx_data_q;
        trmt       = trmt_q;
        resp_sent  = resp_sent_q;
    end

endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// Directed self-checking bench for uart_cmd_wrapper (timeout checks follow UCW_TIMEOUT_EN).
module tb_uart_cmd_wrapper;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = '0;
    logic        rx_rdy = 1'b0;
    logic        clr_rx_rdy;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy = 1'b0;
    logic        cmd_ovr;
    logic        frame_err;
    logic [7:0]  resp = '0;
    logic        send_resp = 1'b0;
    logic        resp_sent;
    logic [7:0]  tx_data;
    logic        trmt;
    logic        tx_done = 1'b0;

    int checks = 0;
    int failures = 0;

    uart_cmd_wrapper #(.TIMEOUT_CYCLES(16), .TO_W(5)) dut (
        .clk(clk), .rst(rst),
        .rx_data(rx_data), .rx_rdy(rx_rdy), .clr_rx_rdy(clr_rx_rdy),
        .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy),
        .cmd_ovr(cmd_ovr), .frame_err(frame_err),
        .resp(resp), .send_resp(send_resp), .resp_sent(resp_sent),
        .tx_data(tx_data), .trmt(trmt), .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one byte for one clock and checks it is consumed combinationally.
    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_rdy  = 1'b1;
        #1;
        chk("clr_rx_rdy_hi", 16'(clr_rx_rdy), 16'h1);
        tick();
        rx_rdy = 1'b0;
        #1;
        chk("clr_rx_rdy_lo", 16'(clr_rx_rdy), 16'h0);
    endtask

    initial begin
        #12;
        chk("rst_cmd", cmd, 16'h0);
        chk("rst_cmd_rdy", 16'(cmd_rdy), 16'h0);
        chk("rst_trmt", 16'(trmt), 16'h0);
        chk("rst_resp_sent", 16'(resp_sent), 16'h0);
        chk("rst_tx_data", 16'(tx_data), 16'h0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Basic two-byte command and consume.
        send_byte(8'hA5);
        chk("t1_rdy_mid", 16'(cmd_rdy), 16'h0);
        chk("t1_cmd_mid", cmd, 16'h0);
        send_byte(8'h3C);
        chk("t1_cmd", cmd, 16'hA53C);
        chk("t1_rdy", 16'(cmd_rdy), 16'h1);
        chk("t1_ovr", 16'(cmd_ovr), 16'h0);
        clr_cmd_rdy = 1'b1;
        tick();
        clr_cmd_rdy = 1'b0;
        chk("t1_rdy_clr", 16'(cmd_rdy), 16'h0);
        chk("t1_cmd_hold", cmd, 16'hA53C);

        // Overrun: second command while first still pending.
        send_byte(8'h12);
        send_byte(8'h34);
        chk("t2_cmd1", cmd, 16'h1234);
        chk("t2_ovr1", 16'(cmd_ovr), 16'h0);
        send_byte(8'hBE);
        chk("t2_cmd_stable", cmd, 16'h1234);
        send_byte(8'hEF);
        chk("t2_ovr", 16'(cmd_ovr), 16'h1);
        chk("t2_cmd", cmd, 16'hBEEF);
        chk("t2_rdy", 16'(cmd_rdy), 16'h1);
        tick();
        chk("t2_ovr_end", 16'(cmd_ovr), 16'h0);
        chk("t2_rdy_hold", 16'(cmd_rdy), 16'h1);

        // Transmit path, including a dropped request while busy.
        resp = 8'hA5;
        send_resp = 1'b1;
        tick();
        send_resp = 1'b0;
        chk("t3_trmt", 16'(trmt), 16'h1);
        chk("t3_tx_data", 16'(tx_data), 16'h00A5);
        chk("t3_sent0", 16'(resp_sent), 16'h0);
        resp = 8'h5A;
        send_resp = 1'b1;
        tick();
        send_resp = 1'b0;
        chk("t3_trmt_once", 16'(trmt), 16'h0);
        chk("t3_tx_hold", 16'(tx_data), 16'h00A5);
        tick();
        chk("t3_busy_trmt", 16'(trmt), 16'h0);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("t3_sent1", 16'(resp_sent), 16'h1);
        chk("t3_tx_final", 16'(tx_data), 16'h00A5);

`ifdef UCW_TIMEOUT_EN
        // Timeout: frame_err 16 clocks after the high byte.
        send_byte(8'h12);
        for (int i = 1; i < 16; i++) begin
            if (frame_err !== 1'b0) chk("t4_fe_early", 16'(frame_err), 16'h0);
            tick();
        end
        chk("t4_fe_early_last", 16'(frame_err), 16'h0);
        tick();
        chk("t4_fe", 16'(frame_err), 16'h1);
        chk("t4_cmd_kept", cmd, 16'hBEEF);
        chk("t4_rdy_kept", 16'(cmd_rdy), 16'h1);
        tick();
        chk("t4_fe_end", 16'(frame_err), 16'h0);
        send_byte(8'h56);
        send_byte(8'h78);
        chk("t4_cmd", cmd, 16'h5678);
`else
        // No timeout: the low byte may arrive arbitrarily late.
        send_byte(8'h12);
        for (int i = 0; i < 40; i++) tick();
        chk("t4_fe_off", 16'(frame_err), 16'h0);
        chk("t4_cmd_kept", cmd, 16'hBEEF);
        send_byte(8'h34);
        chk("t4_cmd", cmd, 16'h1234);
`endif

        // Reset mid-frame and mid-transmit.
        send_byte(8'h99);
        resp = 8'h77;
        send_resp = 1'b1;
        tick();
        send_resp = 1'b0;
        chk("t5_pre_trmt", 16'(trmt), 16'h1);
        rx_rdy = 1'b1;
        rx_data = 8'h44;
        rst = 1'b1;
        #1;
        chk("t5_cmd", cmd, 16'h0);
        chk("t5_rdy", 16'(cmd_rdy), 16'h0);
        chk("t5_trmt", 16'(trmt), 16'h0);
        chk("t5_tx_data", 16'(tx_data), 16'h0);
        chk("t5_sent", 16'(resp_sent), 16'h0);
        chk("t5_clr_rx", 16'(clr_rx_rdy), 16'h0);
        rx_rdy = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        send_byte(8'h01);
        chk("t5_rdy_mid", 16'(cmd_rdy), 16'h0);
        send_byte(8'h02);
        chk("t5_cmd_new", cmd, 16'h0102);

        // Completion, send_resp and clr_cmd_rdy in one clock.
        send_byte(8'hAA);
        rx_data = 8'hBB;
        rx_rdy = 1'b1;
        resp = 8'hC3;
        send_resp = 1'b1;
        clr_cmd_rdy = 1'b1;
        tick();
        rx_rdy = 1'b0;
        send_resp = 1'b0;
        clr_cmd_rdy = 1'b0;
        chk("t6_rdy", 16'(cmd_rdy), 16'h1);
        chk("t6_cmd", cmd, 16'hAABB);
        chk("t6_ovr", 16'(cmd_ovr), 16'h0);
        chk("t6_trmt", 16'(trmt), 16'h1);
        chk("t6_tx_data", 16'(tx_data), 16'h00C3);
        tick();
        chk("t6_trmt_end", 16'(trmt), 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
